// File: rtl/ram8_if.sv
// Bus bundle for the eight-word register memory: write data, write enable,
// word select and the combinational read-back word.
`timescale 1ns/1ps
interface ram8_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
);
    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  out;

    // Requester side: drives the write/select signals, receives the read word
    modport master (
        output in,
        output load,
        output address,
        input  out
    );

    // Memory side: samples the write/select signals, returns the read word
    modport slave (
        input  in,
        input  load,
        input  address,
        output out
    );
endinterface

// File: rtl/ram8.sv
// ram8: eight 16-bit registers with async active-low clear.
// Writes go through a 1-to-8 dmux tree of the load strobe; reads come back
// through an 8-to-1 mux tree, so out follows address with no clock delay and
// shows the old word during the cycle of a write.
`timescale 1ns/1ps
module ram8 (
    input  logic  clk,
    input  logic  rst_n,
    ram8_if.slave bus
);
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;

    logic [WIDTH-1:0] word [DEPTH];

    logic [1:0]       en_l1;
    logic [3:0]       en_l2;
    logic [DEPTH-1:0] word_en;

    logic [WIDTH-1:0] rd_l1 [4];
    logic [WIDTH-1:0] rd_l2 [2];

    // Dmux tree, first level: split load on address[2]
    assign en_l1[1] = bus.load &  bus.address[2];
    assign en_l1[0] = bus.load & ~bus.address[2];

    // Dmux tree, remaining levels: split on address[1], then address[0]
    for (genvar g = 0; g < 2; g++) begin : g_dmux_l2
        assign en_l2[2*g+1] = en_l1[g] &  bus.address[1];
        assign en_l2[2*g]   = en_l1[g] & ~bus.address[1];
    end

    for (genvar g = 0; g < 4; g++) begin : g_dmux_l3
        assign word_en[2*g+1] = en_l2[g] &  bus.address[0];
        assign word_en[2*g]   = en_l2[g] & ~bus.address[0];
    end

    // Word storage: clear on reset, otherwise load only the enabled word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                word[ADDR_W'(i)] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (word_en[ADDR_W'(i)]) begin
                    word[ADDR_W'(i)] <= bus.in;
                end
            end
        end
    end

    // Mux tree, first level: pick within word pairs on address[0]
    for (genvar g = 0; g < 4; g++) begin : g_mux_l1
        assign rd_l1[g] = bus.address[0] ? word[2*g+1] : word[2*g];
    end

    // Mux tree, second level: pick within pair groups on address[1]
    for (genvar g = 0; g < 2; g++) begin : g_mux_l2
        assign rd_l2[g] = bus.address[1] ? rd_l1[2*g+1] : rd_l1[2*g];
    end

    // Mux tree root: pick the half on address[2]
    assign bus.out = bus.address[2] ? rd_l2[1] : rd_l2[0];

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: a table of write/readback vectors, hand-written
// corner sequences, and randomized traffic against an array model.
`timescale 1ns/1ps
module tb_ram8;
    logic clk;
    logic rst_n;

    ram8_if #(.WIDTH(16), .ADDR_W(3)) bus ();

    ram8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        load;
        logic [2:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_out;
    } vec_t;

    vec_t        tbl [16];
    logic [15:0] model [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: addr=%0d got %h expected %h", name, bus.address, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 8; a++) model[a] = 16'h0000;
    endtask

    // Walk every address and compare against the model; 1 ns per address
    task automatic sweep(input string name);
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            check(name, bus.out, model[a]);
        end
    endtask

    initial begin
        // Vector table: write 1111*a to each word (old content 0 visible), then read back
        for (int a = 0; a < 8; a++) begin
            tbl[a]   = '{1'b1, 3'(a), 16'(16'h1111 * a), 16'h0000};
            tbl[a+8] = '{1'b0, 3'(a), 16'hFFFF,          16'(16'h1111 * a)};
        end

        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.address = 3'd0;
        bus.in      = 16'h0000;
        model_clear();

        // Power-on reset, then put something in a word so the later reset matters
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("por", bus.out, 16'h0000);
        @(negedge clk);
        bus.load = 1'b1; bus.address = 3'd2; bus.in = 16'h1234;
        @(negedge clk);
        bus.load = 1'b0;
        #1 check("pre_rst", bus.out, 16'h1234);

        // Async reset mid-cycle, away from any clock edge
        #2 rst_n = 1'b0;
        model_clear();
        #1 check("rst_async", bus.out, 16'h0000);
        bus.load = 1'b1; bus.in = 16'hFFFF;
        sweep("rst_sweep");
        @(negedge clk);
        sweep("rst_ignore_wr");
        bus.load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release", bus.out, 16'h0000);

        // Table-driven write then readback
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.load = tbl[i].load; bus.address = tbl[i].addr; bus.in = tbl[i].din;
            #1 check("tbl", bus.out, tbl[i].exp_out);
            if (tbl[i].load) model[tbl[i].addr] = tbl[i].din;
        end

        // Read-during-write on word 3
        @(negedge clk);
        bus.load = 1'b1; bus.address = 3'd3; bus.in = 16'hBEEF;
        #1 check("rdw_old", bus.out, 16'h3333);
        model[3] = 16'hBEEF;
        @(negedge clk);
        bus.load = 1'b0;
        #1 check("rdw_new", bus.out, 16'hBEEF);
        sweep("rdw_others");

        // Hold: load low with all-ones data for 20 cycles
        bus.in = 16'hFFFF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.address = 3'($urandom_range(0, 7));
            #1 check("hold", bus.out, model[bus.address]);
        end
        sweep("hold_sweep");

        // Reset asserted on the same edge as a write to word 5
        @(negedge clk);
        bus.load = 1'b1; bus.address = 3'd5; bus.in = 16'hA5A5;
        @(posedge clk);
        rst_n = 1'b0;
        model_clear();
        #1 check("rst_vs_wr", bus.out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.address = 3'd5;
        #1 check("rst_vs_wr_rel", bus.out, 16'h0000);
        @(negedge clk);
        bus.load = 1'b0;
        model[5] = 16'hA5A5;
        #1 check("wr_after_rel", bus.out, 16'hA5A5);
        sweep("post_rst_sweep");

        // Random traffic with sporadic async resets
        for (int c = 0; c < 2000; c++) begin
            logic        ld;
            logic [2:0]  ad;
            logic [15:0] dv;
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_clear();
                #1 check("rand_rst", bus.out, 16'h0000);
                #1 rst_n = 1'b1;
            end
            ld = 1'($urandom_range(0, 1));
            ad = 3'($urandom_range(0, 7));
            dv = 16'($urandom);
            bus.load = ld; bus.address = ad; bus.in = dv;
            #1 check("rand", bus.out, model[ad]);
            if (ld) model[ad] = dv;
        end
        @(negedge clk);
        bus.load = 1'b0;
        sweep("rand_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
